// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU M-cycle bus (T1..T4 phases, byte RAM).
// Optional trace ports: define CPU_BUS_RESPONDER_TRACE_EN.
module cpu_bus_responder #(
  parameter int unsigned ADR_BITS = 8,
  parameter logic [15:0] BASE     = 16'hC000,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        mcyc_start,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  din,
  output logic [1:0]  tphase,
  output logic        busy,
  output logic        err
`ifdef CPU_BUS_RESPONDER_TRACE_EN
  ,
  output logic [15:0] last_wr_adr,
  output logic [7:0]  last_wr_dat,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned DEPTH    = 1 << ADR_BITS;
  localparam logic [15:0] ADR_MASK = 16'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_T4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]         r_adr;
  logic                r_rd;
  logic                r_wr;
  logic [7:0]          r_wdat;
  logic [7:0]          r_din;
  logic                r_err;
  logic [7:0]          r_mem [DEPTH];
  logic [ADR_BITS-1:0] w_idx;
  logic                w_hit;
  logic                w_commit;
  logic                w_early;
  logic                w_conflict;

  assign w_idx      = r_adr[ADR_BITS-1:0];
  assign w_hit      = (r_adr & ~ADR_MASK) == BASE;
  assign w_commit   = (r_state == S_T4) && r_wr && w_hit;
  assign w_early    = mcyc_start &&
                      (r_state inside {S_T1, S_T2, S_T3});
  assign w_conflict = mcyc_start && cpu_rd && cpu_wr;

  assign din = r_din;
  assign err = r_err;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    tphase = 2'd0;
    busy   = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_IDLE;
      S_T1: begin
        w_next = S_T2;
        busy   = 1'b1;
      end
      S_T2: begin
        w_next = S_T3;
        tphase = 2'd1;
        busy   = 1'b1;
      end
      S_T3: begin
        w_next = S_T4;
        tphase = 2'd2;
        busy   = 1'b1;
      end
      S_T4: begin
        w_next = S_IDLE;
        tphase = 2'd3;
        busy   = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    // A start pulse in any phase begins a fresh T1.
    if (mcyc_start) w_next = S_T1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_adr  <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_wdat <= '0;
      r_din  <= OPEN_BUS;
      r_err  <= 1'b0;
    end else begin
      if (mcyc_start) begin
        r_adr <= cpu_adr;
        // rd+wr together degrades to a no-op cycle
        r_rd  <= cpu_rd && !cpu_wr;
        r_wr  <= cpu_wr && !cpu_rd;
        r_din <= OPEN_BUS;
      end else if (r_state == S_T1) begin
        r_din <= (r_rd && w_hit) ? r_mem[w_idx] : OPEN_BUS;
      end else if (r_state inside {S_IDLE, S_T4}) begin
        r_din <= OPEN_BUS;
      end
      if (r_state == S_T3) r_wdat <= cpu_dout;
      if (w_early || w_conflict) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= r_wdat;
  end

`ifdef CPU_BUS_RESPONDER_TRACE_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_wr_adr <= '0;
      last_wr_dat <= '0;
      wr_count    <= '0;
    end else if (w_commit) begin
      last_wr_adr <= r_adr;
      last_wr_dat <= r_wdat;
      wr_count    <= wr_count + 16'd1;
    end
  end
`endif

endmodule
